// File: rtl/locked_counter_pkg.sv
// Shared types and constants for the key-locked up/down counter.
// Holds the FSM state encoding and the default unlock key.
// No logic lives here.
package locked_counter_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_KEY_VALUE = 16'hA5C3;

endpackage

// File: rtl/locked_counter_key_checker.sv
// Serial key shift register, key comparator and failed-attempt counter.
// Latency: match/lockout_hit are combinational during the CHECK cycle.
// Backpressure: none; shifting is gated by the caller.
//
// Ports: clk, rst (async, active-high), shift_en/key_bit (serial load,
// MSB first), check_en (high during CHECK), match and lockout_hit
// (single-cycle pulses consumed by the top-level FSM).
// Macro LOCKED_COUNTER_LOCKOUT_EN enables fail_cnt and lockout_hit.
module key_checker
    import locked_counter_pkg::*;
#(
    parameter int                   KEY_SIZE  = 16,
    parameter logic [KEY_SIZE-1:0]  KEY_VALUE = KEY_SIZE'(DEFAULT_KEY_VALUE),
    parameter int                   MAX_TRIES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic key_bit,
    input  logic check_en,
    output logic match,
    output logic lockout_hit
);

    logic [KEY_SIZE-1:0] key_sr;
    logic                key_eq;

    assign key_eq = (key_sr == KEY_VALUE);
    assign match  = check_en && key_eq;

    // The register is wiped after every check so a failed attempt never
    // leaves usable key material behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sr <= '0;
        end else if (check_en) begin
            key_sr <= '0;
        end else if (shift_en) begin
            key_sr <= {key_sr[KEY_SIZE-2:0], key_bit};
        end
    end

`ifdef LOCKED_COUNTER_LOCKOUT_EN
    localparam int FW = $clog2(MAX_TRIES + 1);

    logic [FW-1:0] fail_cnt;
    logic [FW-1:0] fail_inc;

    assign fail_inc    = fail_cnt + FW'(1);
    assign lockout_hit = check_en && !key_eq && (fail_inc == FW'(MAX_TRIES));

    // Counts consecutive failures; a good key resets the streak.
    // Cannot overflow: the MAX_TRIES-th failure parks the FSM in LOCKOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt <= '0;
        end else if (check_en) begin
            fail_cnt <= key_eq ? '0 : fail_inc;
        end
    end
`else
    assign lockout_hit = 1'b0;
`endif

endmodule

// File: rtl/locked_counter.sv
// Key-locked up/down counter: output forced to zero until the right key is entered.
// Latency: key_check to unlocked is 2 cycles; incr/decr to data_out is 1 cycle.
// Backpressure: none; requests arriving in the wrong state are dropped.
//
// Ports: clk, rst (async, active-high); key_shift/key_bit serial key load
// (MSB first); key_check starts a comparison; relock returns to LOCKED;
// do_incr/do_decr count requests; data_out/unlocked/locked_out are decodes
// of registered state.
// Macro LOCKED_COUNTER_LOCKOUT_EN enables permanent lockout after
// MAX_TRIES consecutive failed checks (cleared only by rst).
module locked_counter
    import locked_counter_pkg::*;
#(
    parameter int                   WIDTH     = 8,
    parameter int                   KEY_SIZE  = 16,
    parameter logic [KEY_SIZE-1:0]  KEY_VALUE = KEY_SIZE'(DEFAULT_KEY_VALUE),
    parameter int                   MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_shift,
    input  logic             key_bit,
    input  logic             key_check,
    input  logic             relock,
    input  logic             do_incr,
    input  logic             do_decr,
    output logic [WIDTH-1:0] data_out,
    output logic             unlocked,
    output logic             locked_out
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count;
    logic             match;
    logic             lockout_hit;

    key_checker #(
        .KEY_SIZE  (KEY_SIZE),
        .KEY_VALUE (KEY_VALUE),
        .MAX_TRIES (MAX_TRIES)
    ) u_key_checker (
        .clk         (clk),
        .rst         (rst),
        .shift_en    ((state == LOCKED) && key_shift),
        .key_bit     (key_bit),
        .check_en    (state == CHECK),
        .match       (match),
        .lockout_hit (lockout_hit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            LOCKED:   if (key_check) state_nxt = CHECK;
            CHECK: begin
                if (match)            state_nxt = UNLOCKED;
                else if (lockout_hit) state_nxt = LOCKOUT;
                else                  state_nxt = LOCKED;
            end
            UNLOCKED: if (relock) state_nxt = LOCKED;
            LOCKOUT:  state_nxt = LOCKOUT;
            default:  state_nxt = LOCKED;
        endcase
    end

    // Counter only moves while unlocked; relock wins over a same-cycle
    // request, and incr+decr together cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if ((state == UNLOCKED) && !relock) begin
            if (do_incr && !do_decr) begin
                count <= count + WIDTH'(1);
            end else if (do_decr && !do_incr) begin
                count <= count - WIDTH'(1);
            end
        end
    end

    // Output decode
    always_comb begin
        unlocked = (state == UNLOCKED);
        data_out = unlocked ? count : '0;
`ifdef LOCKED_COUNTER_LOCKOUT_EN
        locked_out = (state == LOCKOUT);
`else
        locked_out = 1'b0;
`endif
    end

endmodule

// File: tb/tb_locked_counter.sv
// Directed bench for locked_counter with default parameters.
// Lockout expectations follow LOCKED_COUNTER_LOCKOUT_EN.
module tb_locked_counter;

`ifdef LOCKED_COUNTER_LOCKOUT_EN
    localparam bit LOCKOUT_ON = 1'b1;
`else
    localparam bit LOCKOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_shift = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_check = 1'b0;
    logic       relock = 1'b0;
    logic       do_incr = 1'b0;
    logic       do_decr = 1'b0;
    logic [7:0] data_out;
    logic       unlocked;
    logic       locked_out;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    locked_counter dut (
        .clk        (clk),
        .rst        (rst),
        .key_shift  (key_shift),
        .key_bit    (key_bit),
        .key_check  (key_check),
        .relock     (relock),
        .do_incr    (do_incr),
        .do_decr    (do_decr),
        .data_out   (data_out),
        .unlocked   (unlocked),
        .locked_out (locked_out)
    );

    typedef struct {
        logic       ks, kb, kc, rl, inc, dec;
        logic [7:0] exp_data;
        logic       exp_unl;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_outs(input string nm, input logic [7:0] d, input logic u, input logic lo);
        chk({nm, ".data_out"}, 32'(data_out), 32'(d));
        chk({nm, ".unlocked"}, 32'(unlocked), 32'(u));
        chk({nm, ".locked_out"}, 32'(locked_out), 32'(lo));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        key_shift = 0; key_bit = 0; key_check = 0;
        relock = 0; do_incr = 0; do_decr = 0;
    endtask

    // Shift the low n bits of k, MSB first; optionally raise key_check on the last bit.
    task automatic shift_bits(input logic [15:0] k, input int n, input bit chk_last);
        for (int i = n - 1; i >= 0; i--) begin
            key_shift = 1'b1;
            key_bit   = k[i];
            key_check = chk_last && (i == 0);
            tick();
        end
        idle();
    endtask

    // Full key then a separate key_check pulse; returns one edge after CHECK.
    task automatic try_key(input logic [15:0] k);
        shift_bits(k, 16, 1'b0);
        key_check = 1'b1;
        tick();
        key_check = 1'b0;
        chk("in_check.unlocked", 32'(unlocked), 32'd0);
        tick();
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outs("async_rst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // {ks, kb, kc, rl, inc, dec, exp_data, exp_unl}; rows 0-3 start at 0x0A, rows 4-11 at 0x00
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1};

        // Reset state
        tick();
        tick();
        check_outs("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Increments are dropped while locked
        for (int i = 0; i < 5; i++) begin
            do_incr = 1'b1;
            tick();
        end
        idle();
        check_outs("locked_incr", 8'h00, 1'b0, 1'b0);

        // Correct key: unlocked two edges after key_check
        try_key(16'hA5C3);
        check_outs("unlock", 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_incr = 1'b1;
            tick();
        end
        idle();
        check_outs("count10", 8'h0A, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            if (i == 4) begin
                for (int j = 0; j < 9; j++) begin
                    do_decr = 1'b1;
                    tick();
                end
                idle();
                chk("down_to_zero", 32'(data_out), 32'h00);
            end
            key_shift = vecs[i].ks; key_bit = vecs[i].kb; key_check = vecs[i].kc;
            relock = vecs[i].rl; do_incr = vecs[i].inc; do_decr = vecs[i].dec;
            tick();
            idle();
            chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d.unlocked", i), 32'(unlocked), 32'(vecs[i].exp_unl));
        end

        // Count to 0x05, relock with a simultaneous incr, then re-enter key
        for (int i = 0; i < 4; i++) begin
            do_incr = 1'b1;
            tick();
        end
        idle();
        chk("count5", 32'(data_out), 32'h05);
        relock = 1'b1; do_incr = 1'b1;
        tick();
        idle();
        check_outs("relock", 8'h00, 1'b0, 1'b0);
        tick();
        check_outs("relock_hold", 8'h00, 1'b0, 1'b0);
        shift_bits(16'hA5C3, 16, 1'b1);   // check on the last shift
        chk("shift_check.unlocked", 32'(unlocked), 32'd0);
        tick();
        check_outs("reentry", 8'h05, 1'b1, 1'b0);

        // Two failures, then success clears the failure streak
        relock = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            try_key(16'h1234);
            check_outs($sformatf("fail_a%0d", i), 8'h00, 1'b0, 1'b0);
        end
        try_key(16'hA5C3);
        check_outs("clear_streak", 8'h05, 1'b1, 1'b0);
        relock = 1'b1;
        tick();
        idle();

        // Consecutive failures: lockout on the third only when enabled
        for (int i = 0; i < 4; i++) begin
            try_key(16'h1234);
            check_outs($sformatf("fail_b%0d", i), 8'h00, 1'b0, LOCKOUT_ON && (i >= 2));
        end
        try_key(16'hA5C3);
        check_outs("after_fails", LOCKOUT_ON ? 8'h00 : 8'h05, !LOCKOUT_ON, LOCKOUT_ON);

        // Async reset clears everything, including lockout
        pulse_rst();
        tick();
        check_outs("post_rst", 8'h00, 1'b0, 1'b0);

        // Partial key discarded by reset: A5 then rst then C3 must not match
        shift_bits(16'h00A5, 8, 1'b0);
        pulse_rst();
        shift_bits(16'h00C3, 8, 1'b1);
        tick();
        check_outs("partial_discard", 8'h00, 1'b0, 1'b0);
        try_key(16'hA5C3);
        check_outs("unlock_after_rst", 8'h00, 1'b1, 1'b0);
        do_incr = 1'b1;
        tick();
        idle();
        chk("final_incr", 32'(data_out), 32'h01);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
